pipelined_cla_adder: RTL

//  Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake on both sides.

---
 rtl/pipelined_cla_adder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: pipelined carry-lookahead adder/subtractor with
// valid/ready handshakes on input and output.
// Optional feature macro: PIPELINED_CLA_ADDER_SAT_EN adds port sat_in and
// clamps the result on signed overflow; without it results always wrap.
//
// Handshake: a beat moves across a boundary only at a rising clk edge where
// its valid and the receiver's ready are both high; the sender holds its data
// stable while valid is high and ready is low. in_ready is combinational from
// out_ready through the per-stage advance chain.
module pipelined_cla_adder #(
    parameter int NUMBITS   = 32,
    parameter int BLOCKSIZE = 4,
    parameter int STAGES    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] a_in,
    input  logic [NUMBITS-1:0] b_in,
    input  logic               c_in,
    input  logic               sub_in,
`ifdef PIPELINED_CLA_ADDER_SAT_EN
    input  logic               sat_in,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] s_out,
    output logic               c_out,
    output logic               ovf_out
);

    localparam int NBLK = NUMBITS / BLOCKSIZE;
    localparam int G    = NBLK / STAGES;      // lookahead blocks per stage
    localparam int SW   = G * BLOCKSIZE;      // bits resolved per stage
    localparam int LAST = STAGES - 1;
    localparam int MSB  = NUMBITS - 1;

    if ((STAGES < 1) || ((NUMBITS % BLOCKSIZE) != 0) || ((NBLK % STAGES) != 0)) begin : g_param_check
        $error("pipelined_cla_adder: NUMBITS must be a multiple of BLOCKSIZE and STAGES must divide NUMBITS/BLOCKSIZE");
    end

    // One stage's group: block generate/propagate, lookahead block carries,
    // then lookahead bit carries inside each block. Returns {carry_out, sum}.
    function automatic logic [SW:0] cla_group(input logic [SW-1:0] a,
                                              input logic [SW-1:0] b,
                                              input logic          cin);
        logic [SW-1:0]        g, p, s;
        logic [G-1:0]         bg, bp;
        logic [G:0]           bc;
        logic [BLOCKSIZE-1:0] c;
        logic                 term;
        g = a & b;
        p = a ^ b;
        s = '0;
        c = '0;
        for (int j = 0; j < G; j++) begin
            bg[j] = 1'b0;
            bp[j] = 1'b1;
            for (int i = 0; i < BLOCKSIZE; i++) begin
                term = g[j*BLOCKSIZE+i];
                for (int m = i + 1; m < BLOCKSIZE; m++) term = term & p[j*BLOCKSIZE+m];
                bg[j] = bg[j] | term;
                bp[j] = bp[j] & p[j*BLOCKSIZE+i];
            end
        end
        bc[0] = cin;
        for (int j = 1; j <= G; j++) begin
            term = cin;
            for (int m = 0; m < j; m++) term = term & bp[m];
            bc[j] = term;
            for (int i = 0; i < j; i++) begin
                term = bg[i];
                for (int m = i + 1; m < j; m++) term = term & bp[m];
                bc[j] = bc[j] | term;
            end
        end
        for (int j = 0; j < G; j++) begin
            for (int i = 0; i < BLOCKSIZE; i++) begin
                term = bc[j];
                for (int m = 0; m < i; m++) term = term & p[j*BLOCKSIZE+m];
                c[i] = term;
                for (int q = 0; q < i; q++) begin
                    term = g[j*BLOCKSIZE+q];
                    for (int m = q + 1; m < i; m++) term = term & p[j*BLOCKSIZE+m];
                    c[i] = c[i] | term;
                end
                s[j*BLOCKSIZE+i] = p[j*BLOCKSIZE+i] ^ c[i];
            end
        end
        return {bc[G], s};
    endfunction

    // Subtraction is a + ~b + 1, so c_in is ignored in that mode.
    logic [NUMBITS-1:0] b_eff;
    logic               c_eff;
    assign b_eff = sub_in ? ~b_in : b_in;
    assign c_eff = sub_in | c_in;

    logic [STAGES-1:0] v_q, adv, in_v, ld;

    // Advance chain: a stage moves when empty or when everything after it moves.
    always_comb begin : ready_chain
        logic acc;
        acc = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            acc    = acc | ~v_q[k];
            adv[k] = acc;
        end
    end

    // Valid presented to each stage: input port for stage 0, previous stage otherwise.
    always_comb begin
        in_v    = '0;
        in_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) in_v[k] = v_q[k-1];
    end

    assign ld       = adv & in_v;
    assign in_ready = adv[0];

    // Stage valid bits; data registers only load when a valid beat enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) v_q[k] <= in_v[k];
            end
        end
    end

`ifdef PIPELINED_CLA_ADDER_SAT_EN
    logic [STAGES-1:0] sat_q, sat_src;

    // Saturation request source per stage.
    always_comb begin
        sat_src    = '0;
        sat_src[0] = sat_in;
        for (int k = 1; k < STAGES; k++) sat_src[k] = sat_q[k-1];
    end

    // Saturation request travels alongside its beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) sat_q[k] <= sat_src[k];
            end
        end
    end
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SW;
        localparam int HI = LO + SW;

        // Operand bits not yet resolved: [NUMBITS-1:LO] of the original operands.
        logic [NUMBITS-LO-1:0] a_i, b_i;
        logic                  c_i;
        logic [SW-1:0]         grp_s;
        logic                  grp_c;
        logic [HI-1:0]         s_n, s_q;
        logic                  c_q;

        if (k == 0) begin : g_src
            assign a_i = a_in;
            assign b_i = b_eff;
            assign c_i = c_eff;
            assign s_n = grp_s;
        end else begin : g_chain
            assign a_i = g_st[k-1].g_fwd.a_q;
            assign b_i = g_st[k-1].g_fwd.b_q;
            assign c_i = g_st[k-1].c_q;
            assign s_n = {grp_s, g_st[k-1].s_q};
        end

        assign {grp_c, grp_s} = cla_group(a_i[SW-1:0], b_i[SW-1:0], c_i);

        // Resolved sum bits and the group carry handed to the next stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (ld[k]) begin
                s_q <= s_n;
                c_q <= grp_c;
            end
        end

        if (k < LAST) begin : g_fwd
            logic [NUMBITS-HI-1:0] a_q, b_q;

            // Skew the still-unresolved operand bits forward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (ld[k]) begin
                    a_q <= a_i[NUMBITS-LO-1:SW];
                    b_q <= b_i[NUMBITS-LO-1:SW];
                end
            end
        end else begin : g_end
            logic ovf_q;

            // Signed overflow: operands agree in sign and the sum sign differs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (ld[k]) begin
                    ovf_q <= (a_i[NUMBITS-LO-1] == b_i[NUMBITS-LO-1]) &&
                             (s_n[HI-1] != a_i[NUMBITS-LO-1]);
                end
            end
        end
    end

    logic [NUMBITS-1:0] raw_s;
    assign raw_s     = g_st[LAST].s_q;
    assign c_out     = g_st[LAST].c_q;
    assign ovf_out   = g_st[LAST].g_end.ovf_q;
    assign out_valid = v_q[LAST];

`ifdef PIPELINED_CLA_ADDER_SAT_EN
    // A wrapped positive overflow shows a set sign bit; clamp toward the true sign.
    assign s_out = (sat_q[LAST] && ovf_out) ? {~raw_s[MSB], {(NUMBITS-1){raw_s[MSB]}}} : raw_s;
`else
    assign s_out = raw_s;
`endif

endmodule
